// File: rtl/line_frame_pkg.sv
// Shared constants and FSM state types for the scan-line frame packer.
package line_frame_pkg;

    localparam logic [7:0] SYNC0 = 8'hAA;
    localparam logic [7:0] SYNC1 = 8'h55;

    typedef enum logic {
        W_IDLE,
        W_FILL
    } wr_state_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_SYNC0,
        R_SYNC1,
        R_HDR,
        R_DATA,
        R_CSUM
    } rd_state_t;

    function automatic int FRAME_BYTES(input int n);
        return n + 4;
    endfunction

endpackage

// File: rtl/line_buf_dpram.sv
// Simple dual-port line buffer: one write port, one read port with a registered read.
module line_buf_dpram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [0:(1<<AW)-1];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/line_frame_packer.sv
// Collects scan lines into a ping-pong buffer and emits each completed line as
// AA 55 line_no samples csum over a valid/ready byte stream.
module line_frame_packer
    import line_frame_pkg::*;
#(
    parameter int SAMPLES_PER_LINE = 512,
    parameter int ADDR_W           = 9
) (
    input  logic       clk_50M,
    input  logic       reset_n,
    input  logic [7:0] Trans_Data,
    input  logic       data_valid,
    input  logic       line_start,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       overflow,
    output logic       short_line,
    output logic       busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SAMPLES_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    // writer state
    wr_state_t         r_wstate;
    wr_state_t         w_wstate_next;
    logic              r_wbank;
    logic              w_wbank_next;
    logic [ADDR_W-1:0] r_wcnt;
    logic [ADDR_W-1:0] w_wcnt_next;
    logic [7:0]        r_csum_acc;
    logic [7:0]        w_csum_next;
    logic [7:0]        r_line_no;
    logic [7:0]        w_line_no_next;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr_idx;
    logic [1:0]        w_set_full;
    logic              w_hdr_load;
    logic              w_overflow_set;
    logic              w_short_set;

    // shared bank bookkeeping
    logic [1:0]        r_full;
    logic [1:0][7:0]   r_hdr_csum;
    logic [1:0][7:0]   r_hdr_line;
    logic              r_overflow;
    logic              r_short_line;

    // reader state
    rd_state_t         r_rstate;
    rd_state_t         w_rstate_next;
    logic              r_rbank;
    logic              w_rbank_next;
    logic [ADDR_W-1:0] r_rd_idx;
    logic [ADDR_W-1:0] w_rd_idx_next;
    logic [1:0]        w_clr_full;
    logic              w_tx_valid;
    logic              w_accept;
    logic [7:0]        w_tx_data;
    logic [7:0]        w_rd_data;

    line_buf_dpram #(
        .AW(ADDR_W + 1)
    ) u_buf (
        .clk     (clk_50M),
        .i_we    (w_we),
        .i_waddr ({r_wbank, w_waddr_idx}),
        .i_wdata (Trans_Data),
        .i_raddr ({w_rbank_next, w_rd_idx_next}),
        .o_rdata (w_rd_data)
    );

    always_comb begin
        w_wstate_next  = r_wstate;
        w_wbank_next   = r_wbank;
        w_wcnt_next    = r_wcnt;
        w_csum_next    = r_csum_acc;
        w_line_no_next = r_line_no;
        w_we           = 1'b0;
        w_waddr_idx    = '0;
        w_set_full     = 2'b00;
        w_hdr_load     = 1'b0;
        w_overflow_set = 1'b0;
        w_short_set    = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (data_valid && line_start) begin
                    if (r_full[r_wbank]) begin
                        w_overflow_set = 1'b1;
                    end else begin
                        w_we          = 1'b1;
                        w_wcnt_next   = IDX_ONE;
                        w_csum_next   = r_line_no + Trans_Data;
                        w_wstate_next = W_FILL;
                    end
                end
            end
            W_FILL: begin
                if (data_valid) begin
                    w_we = 1'b1;
                    if (line_start) begin
                        // Early restart reuses the same bank from address 0.
                        w_short_set = 1'b1;
                        w_wcnt_next = IDX_ONE;
                        w_csum_next = r_line_no + Trans_Data;
                    end else begin
                        w_waddr_idx = r_wcnt;
                        w_wcnt_next = r_wcnt + IDX_ONE;
                        w_csum_next = r_csum_acc + Trans_Data;
                        if (r_wcnt == LAST_IDX) begin
                            w_set_full[r_wbank] = 1'b1;
                            w_hdr_load          = 1'b1;
                            w_line_no_next      = r_line_no + 8'd1;
                            w_wbank_next        = ~r_wbank;
                            w_wstate_next       = W_IDLE;
                        end
                    end
                end
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_next = r_rstate;
        w_rbank_next  = r_rbank;
        w_rd_idx_next = r_rd_idx;
        w_clr_full    = 2'b00;
        w_tx_valid    = (r_rstate != R_IDLE);
        w_accept      = w_tx_valid && tx_ready;
        case (r_rstate)
            R_IDLE:  if (r_full[r_rbank]) w_rstate_next = R_SYNC0;
            R_SYNC0: if (w_accept) w_rstate_next = R_SYNC1;
            R_SYNC1: if (w_accept) w_rstate_next = R_HDR;
            R_HDR:   if (w_accept) w_rstate_next = R_DATA;
            R_DATA: begin
                // RAM address follows the next index so the read data is ready a cycle ahead.
                if (w_accept) begin
                    w_rd_idx_next = r_rd_idx + IDX_ONE;
                    if (r_rd_idx == LAST_IDX) begin
                        w_rstate_next = R_CSUM;
                    end
                end
            end
            R_CSUM: begin
                if (w_accept) begin
                    w_clr_full[r_rbank] = 1'b1;
                    w_rbank_next        = ~r_rbank;
                    w_rstate_next       = R_IDLE;
                end
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_tx_data = 8'h00;
        case (r_rstate)
            R_SYNC0: w_tx_data = SYNC0;
            R_SYNC1: w_tx_data = SYNC1;
            R_HDR:   w_tx_data = r_hdr_line[r_rbank];
            R_DATA:  w_tx_data = w_rd_data;
            R_CSUM:  w_tx_data = r_hdr_csum[r_rbank];
            default: w_tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            r_wstate     <= W_IDLE;
            r_wbank      <= 1'b0;
            r_wcnt       <= '0;
            r_csum_acc   <= 8'h00;
            r_line_no    <= 8'h00;
            r_full       <= 2'b00;
            r_hdr_csum   <= '0;
            r_hdr_line   <= '0;
            r_overflow   <= 1'b0;
            r_short_line <= 1'b0;
            r_rstate     <= R_IDLE;
            r_rbank      <= 1'b0;
            r_rd_idx     <= '0;
        end else begin
            r_wstate   <= w_wstate_next;
            r_wbank    <= w_wbank_next;
            r_wcnt     <= w_wcnt_next;
            r_csum_acc <= w_csum_next;
            r_line_no  <= w_line_no_next;
            // Set and clear never target the same bank: the writer only fills an empty bank.
            r_full     <= (r_full & ~w_clr_full) | w_set_full;
            if (w_hdr_load) begin
                r_hdr_csum[r_wbank] <= w_csum_next;
                r_hdr_line[r_wbank] <= r_line_no;
            end
            if (w_overflow_set) r_overflow <= 1'b1;
            if (w_short_set)    r_short_line <= 1'b1;
            r_rstate <= w_rstate_next;
            r_rbank  <= w_rbank_next;
            r_rd_idx <= w_rd_idx_next;
        end
    end

    assign tx_data    = w_tx_data;
    assign tx_valid   = w_tx_valid;
    assign overflow   = r_overflow;
    assign short_line = r_short_line;
    assign busy       = (r_wstate == W_FILL) || (r_rstate != R_IDLE);

endmodule
